// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 7-segment display path.
//   seg_t          : 7-bit segment vector ordered {g,f,e,d,c,b,a}, active-high
//   SEG_0..SEG_9   : glyphs for the decimal digits
//   SEG_E          : glyph shown for any nibble that is not a valid BCD digit
//   SEG_OFF        : all segments dark
// ---------------------------------------------------------------------------
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD nibble to 7-segment decoder. Output is active-high;
// the caller applies board polarity.
//   nibble : 4-bit BCD code
//   seg    : {g,f,e,d,c,b,a}; codes above 9 show 'E'
// ---------------------------------------------------------------------------
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Plain lookup; every non-decimal code falls into the 'E' glyph.
  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexed driver for a NUM_DIGITS-digit 7-segment display. A packed
// BCD word is accepted into a shadow buffer and copied to the active buffer
// only when the scan wraps back to digit 0, so a frame never mixes words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 0 darkens all anodes; scanning and buffering keep running
//   bcd_in      : packed BCD, digit 0 in the low nibble
//   bcd_valid   : bcd_in holds a word to take
//   bcd_ready   : shadow buffer free (accept happens on valid && ready)
//   an          : one-hot anode select, polarity per AN_ACTIVE_LOW
//   seg         : {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   digit_idx   : digit currently being scanned
//   frame_tick  : high during the cycle whose closing edge wraps to digit 0
// ---------------------------------------------------------------------------
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic                          bcd_valid,
  output logic                          bcd_ready,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam seg_t                  SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic                    step;
  logic                    wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  seg_t                    digit_seg;
  seg_t                    raw_seg;

  assign step       = (prescaler == PRE_LAST);
  assign wrap       = step && (idx_q == IDX_LAST);
  assign frame_tick = wrap;
  assign bcd_ready  = !pending;
  assign digit_idx  = idx_q;

  // Refresh prescaler and digit pointer; the pointer moves once per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx_q     <= '0;
    end else if (step) begin
      prescaler <= '0;
      idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Double buffer. Ready drops on accept, so a commit always sees the
  // shadow word in full and accept/commit cannot collide on one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (bcd_valid && !pending) begin
        shadow  <= bcd_in;
        pending <= 1'b1;
      end
    end
  end

  // Walk the digits from the most significant end so the running
  // "everything above is zero" flag is ready when the lit digit is reached.
  // Codes above 9 count as non-zero and stop the blanking run.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    cur_nibble = '0;
    cur_blank  = 1'b0;
    onehot     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (active[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = active[4*i +: 4];
        cur_blank  = (BLANK_LZ != 0) && (i != 0) && upper_zero;
        onehot[i]  = 1'b1;
      end
    end
  end

  bcd_to_seg u_decode (
    .nibble (cur_nibble),
    .seg    (digit_seg)
  );

  assign raw_seg = cur_blank ? SEG_OFF : digit_seg;

  // Pin registers: anode and segments are captured together from the same
  // digit pointer, so the pins always agree with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF_PIN;
    end else begin
      if (!enable)
        an <= AN_OFF;
      else
        an <= (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg <= (SEG_ACTIVE_LOW != 0) ? ~raw_seg : raw_seg;
    end
  end

endmodule
